// File: rtl/jaxa_link_control_if.sv
// rtl/jaxa_link_control_if.sv - Avalon-MM register bus bundle for jaxa_link_control
interface jaxa_link_control_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/jaxa_link_control.sv
// rtl/jaxa_link_control.sv - SpaceWire link bring-up/retry sequencer with Avalon-MM registers
// Optional interrupt block (pending/mask at addr3, irq output) enabled by JAXA_LINK_CONTROL_IRQ_EN.
module jaxa_link_control #(
  parameter int DISABLE_CYCLES = 64,
  parameter int START_TIMEOUT  = 20000,
  parameter int BACKOFF_CYCLES = 1000,
  parameter int MAX_RETRY      = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  jaxa_link_control_if.slave  bus,
  input  logic                link_running,
  input  logic                link_error,
  output logic                link_start,
  output logic                link_disable,
  output logic                link_fail,
  output logic                irq
);
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DISABLE_WAIT = 3'd1,
    STARTING     = 3'd2,
    RUNNING      = 3'd3,
    BACKOFF      = 3'd4,
    FAILED       = 3'd5
  } state_t;

  localparam logic [23:0] DIS_LOAD     = 24'(DISABLE_CYCLES - 1);
  localparam logic [23:0] START_LOAD   = 24'(START_TIMEOUT - 1);
  localparam logic [23:0] BACKOFF_LOAD = 24'(BACKOFF_CYCLES - 1);
  localparam logic [3:0]  RETRY_LAST   = 4'(MAX_RETRY - 1);

  state_t      state, state_next;
  logic        enable, enable_next;
  logic [23:0] cnt, cnt_next;
  logic [3:0]  retry_count, retry_next;
  logic [15:0] error_count, error_next;
  logic [31:0] readdata, readdata_next;
  logic [31:0] irq_rdata;
  logic        wr, ctrl_wr, clear, err_inc, attempt_fail;
  logic        unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign ctrl_wr      = wr && (bus.address == 2'd0);
  assign clear        = ctrl_wr && bus.writedata[1];
  // A CTRL write takes effect in the same edge, so disabling reaches IDLE one cycle after the write.
  assign enable_next  = ctrl_wr ? bus.writedata[0] : enable;
  assign unused_wdata = ^bus.writedata[31:2];

  assign link_disable = (state == IDLE) || (state == DISABLE_WAIT) ||
                        (state == BACKOFF) || (state == FAILED);
  assign link_start   = (state == STARTING) || (state == RUNNING);
  assign link_fail    = (state == FAILED);
  assign bus.readdata = readdata;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    retry_next   = retry_count;
    err_inc      = 1'b0;
    attempt_fail = 1'b0;
    if (!enable_next) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = DISABLE_WAIT;
          cnt_next   = DIS_LOAD;
          retry_next = '0;
        end
        DISABLE_WAIT: begin
          if (cnt == '0) begin
            state_next = STARTING;
            cnt_next   = START_LOAD;
          end else begin
            cnt_next = cnt - 24'd1;
          end
        end
        STARTING: begin
          // Error outranks a simultaneous link_running; timeout only matters if neither fires.
          if (link_error) begin
            attempt_fail = 1'b1;
          end else if (link_running) begin
            state_next = RUNNING;
            cnt_next   = '0;
            retry_next = '0;
          end else if (cnt == '0) begin
            attempt_fail = 1'b1;
          end else begin
            cnt_next = cnt - 24'd1;
          end
          if (attempt_fail) begin
            if (retry_count == RETRY_LAST) begin
              state_next = FAILED;
              cnt_next   = '0;
            end else begin
              retry_next = retry_count + 4'd1;
              state_next = BACKOFF;
              cnt_next   = BACKOFF_LOAD;
            end
          end
        end
        RUNNING: begin
          if (link_error || !link_running) begin
            err_inc    = 1'b1;
            state_next = DISABLE_WAIT;
            cnt_next   = DIS_LOAD;
          end
        end
        BACKOFF: begin
          if (cnt == '0) begin
            state_next = STARTING;
            cnt_next   = START_LOAD;
          end else begin
            cnt_next = cnt - 24'd1;
          end
        end
        FAILED: begin
          cnt_next = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
    if (clear) begin
      retry_next = '0;
    end
  end

  always_comb begin
    error_next = error_count;
    if (clear) begin
      error_next = '0;
    end else if (err_inc && (error_count != 16'hFFFF)) begin
      error_next = error_count + 16'd1;
    end
  end

  always_comb begin
    readdata_next = '0;
    case (bus.address)
      2'd0:    readdata_next = {31'd0, enable};
      2'd1:    readdata_next = {error_count, 4'd0, retry_count, 3'd0,
                                link_fail, link_running, state};
      2'd2:    readdata_next = {8'd0, cnt};
      default: readdata_next = irq_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      enable      <= 1'b0;
      cnt         <= '0;
      retry_count <= '0;
      error_count <= '0;
      readdata    <= '0;
    end else begin
      state       <= state_next;
      enable      <= enable_next;
      cnt         <= cnt_next;
      retry_count <= retry_next;
      error_count <= error_next;
      readdata    <= readdata_next;
    end
  end

`ifdef JAXA_LINK_CONTROL_IRQ_EN
  logic pending, pending_next, mask, mask_next, irq_q, irq_wr, link_event;

  assign irq_wr     = wr && (bus.address == 2'd3);
  assign link_event = ((state_next == RUNNING) != (state == RUNNING)) ||
                      ((state_next == FAILED) && (state != FAILED));

  always_comb begin
    pending_next = pending;
    mask_next    = mask;
    if (irq_wr) begin
      mask_next = bus.writedata[1];
      if (bus.writedata[0]) begin
        pending_next = 1'b0;
      end
    end
    // A link event in the same cycle as a clear keeps the bit set.
    if (link_event) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      mask    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      pending <= pending_next;
      mask    <= mask_next;
      irq_q   <= pending_next & mask_next;
    end
  end

  assign irq       = irq_q;
  assign irq_rdata = {30'd0, mask, pending};
`else
  assign irq       = 1'b0;
  assign irq_rdata = '0;
`endif
endmodule

// File: tb/tb_jaxa_link_control.sv
// tb/tb_jaxa_link_control.sv - randomized, model-checked bench for jaxa_link_control
module tb_jaxa_link_control;
  localparam int DIS = 4;
  localparam int TO  = 16;
  localparam int BO  = 8;
  localparam int MR  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic link_running = 1'b0;
  logic link_error = 1'b0;
  logic link_start, link_disable, link_fail, irq;

  jaxa_link_control_if bus();

  jaxa_link_control #(
    .DISABLE_CYCLES(DIS), .START_TIMEOUT(TO), .BACKOFF_CYCLES(BO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .link_running(link_running), .link_error(link_error),
    .link_start(link_start), .link_disable(link_disable),
    .link_fail(link_fail), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Phase numbers follow the STATUS state field; windows are tracked by elapsed cycles.
  int   m_phase, m_age, m_retry, m_err;
  bit   m_en, m_pend, m_mask, m_irq;
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] outs_of(input int p);
    return {(p == 2 || p == 3), (p == 0 || p == 1 || p == 4 || p == 5), (p == 5)};
  endfunction

  function automatic int cnt_of();
    case (m_phase)
      1:       return DIS - 1 - m_age;
      2:       return TO - 1 - m_age;
      4:       return BO - 1 - m_age;
      default: return 0;
    endcase
  endfunction

  task automatic enter(input int p);
    m_phase = p;
    m_age   = 0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_retry = 0; m_err = 0;
    m_en = 0; m_pend = 0; m_mask = 0; m_irq = 0;
  endtask

  task automatic model_step();
    bit wr, ctrl, en_new, over;
    int prev;
    wr     = bus.chipselect && !bus.write_n;
    ctrl   = wr && (bus.address == 2'd0);
    en_new = ctrl ? bus.writedata[0] : m_en;
    case (bus.address)
      2'd0: exp_rd = 32'(m_en);
      2'd1: exp_rd = 32'(m_err * 65536 + m_retry * 256 + (m_phase == 5 ? 16 : 0) +
                         (link_running ? 8 : 0) + m_phase);
      2'd2: exp_rd = 32'(cnt_of());
`ifdef JAXA_LINK_CONTROL_IRQ_EN
      default: exp_rd = 32'(m_mask * 2 + m_pend);
`else
      default: exp_rd = 32'd0;
`endif
    endcase
    prev = m_phase;
    if (!en_new) enter(0);
    else begin
      case (m_phase)
        0: begin enter(1); m_retry = 0; end
        1: if (m_age == DIS - 1) enter(2); else m_age++;
        2: begin
          over = link_error || (!link_running && m_age == TO - 1);
          if (over) begin
            if (m_retry == MR - 1) enter(5);
            else begin m_retry++; enter(4); end
          end else if (link_running) begin
            m_retry = 0; enter(3);
          end else m_age++;
        end
        3: if (link_error || !link_running) begin
             if (m_err < 65535) m_err++;
             enter(1);
           end
        4: if (m_age == BO - 1) enter(2); else m_age++;
        default: ;
      endcase
    end
    if (ctrl && bus.writedata[1]) begin m_retry = 0; m_err = 0; end
    m_en = en_new;
`ifdef JAXA_LINK_CONTROL_IRQ_EN
    if (wr && bus.address == 2'd3) begin
      m_mask = bus.writedata[1];
      if (bus.writedata[0]) m_pend = 0;
    end
    if (((prev == 3) != (m_phase == 3)) || (m_phase == 5 && prev != 5)) m_pend = 1;
`endif
    m_irq = m_pend & m_mask;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("rdata", bus.readdata, exp_rd);
    check("link_outs", 32'({link_start, link_disable, link_fail, irq}),
          32'({outs_of(m_phase), m_irq}));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    tick();
    d = bus.readdata;
  endtask

  task automatic wait_phase(input int p, input int limit);
    int n = 0;
    while (m_phase != p && n < limit) begin tick(); n++; end
    check("wait_phase", 32'({link_start, link_disable, link_fail}), 32'(outs_of(p)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check("reset_link", 32'({link_start, link_disable, link_fail, irq}), 32'(4'b0100));
    check("reset_rdata", bus.readdata, 32'd0);
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

    // 1: bring-up; link_disable held exactly DIS cycles, link comes up 6 cycles into STARTING
    bus_write(2'd0, 32'd1);
    n = 0;
    while (link_disable && n < 50) begin n++; tick(); end
    check("disable_len", n, DIS);
    repeat (5) tick();
    link_running = 1'b1;
    tick();
    bus_read(2'd1, rd);
    check("t1_state", 32'(rd[2:0]), 32'd3);
    check("t1_retry", 32'(rd[11:8]), 32'd0);

    // 2: never links; MR windows separated by backoffs, then FAILED
    link_running = 1'b0;
    bus_write(2'd0, 32'd0);
    bus_write(2'd0, 32'd1);
    n = 0;
    while (!link_fail && n < 200) begin n++; tick(); end
    check("fail_latency", n, DIS + MR * TO + (MR - 1) * BO);
    bus_read(2'd1, rd);
    check("t2_state", 32'(rd[2:0]), 32'd5);
    check("t2_retry", 32'(rd[11:8]), 32'(MR - 1));
    bus_write(2'd0, 32'd0);
    check("t2_unfail", 32'({link_fail, link_start, link_disable}), 32'(3'b001));

    // 3: three link drops while running
    link_running = 1'b1;
    bus_write(2'd0, 32'd3);
    wait_phase(3, 20);
    for (int i = 0; i < 3; i++) begin
      link_running = 1'b0;
      tick();
      link_running = 1'b1;
      wait_phase(3, 20);
    end
    bus_read(2'd1, rd);
    check("t3_errcnt", 32'(rd[31:16]), 32'd3);

    // 4: error and running together, then clear colliding with an increment
    link_running = 1'b0;
    bus_write(2'd0, 32'd0);
    bus_write(2'd0, 32'd1);
    wait_phase(2, 20);
    link_error = 1'b1; link_running = 1'b1;
    tick();
    link_error = 1'b0; link_running = 1'b0;
    bus_read(2'd1, rd);
    check("t4_state", 32'(rd[2:0]), 32'd4);
    check("t4_retry", 32'(rd[11:8]), 32'd1);
    link_running = 1'b1;
    wait_phase(3, 40);
    link_running = 1'b0;
    bus_write(2'd0, 32'd3);
    bus_read(2'd1, rd);
    check("t4_errclr", 32'(rd[31:16]), 32'd0);
    check("t4_state2", 32'(rd[2:0]), 32'd1);

    // 5: asynchronous reset in STARTING
    wait_phase(2, 20);
    tick();
    #3 reset_n = 1'b0;
    #1;
    check("async_link", 32'({link_start, link_disable}), 32'(2'b01));
    check("async_rdata", bus.readdata, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check("post_reset_reg", rd, 32'd0);
    end

    // 6: interrupt register
    bus_write(2'd3, 32'd2);
    link_running = 1'b1;
    bus_write(2'd0, 32'd1);
    wait_phase(3, 20);
`ifdef JAXA_LINK_CONTROL_IRQ_EN
    check("irq_on", 32'(irq), 32'd1);
`else
    check("irq_on", 32'(irq), 32'd0);
`endif
    bus_write(2'd3, 32'd3);
    check("irq_off", 32'(irq), 32'd0);
    bus_read(2'd3, rd);
`ifdef JAXA_LINK_CONTROL_IRQ_EN
    check("irq_reg", rd, 32'd2);
`else
    check("irq_reg", rd, 32'd0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      logic [31:0] d;
      if ($urandom_range(0, 9) == 0) link_running = !link_running;
      link_error = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) begin
        d = $urandom();
        if ($urandom_range(0, 7) != 0) d[0] = 1'b1;
        bus_write(($urandom_range(0, 3) == 0) ? 2'd3 : 2'd0, d);
      end else begin
        bus.address = 2'($urandom_range(0, 3));
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
